// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, state encoding and round functions
package sha256_pkg;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Working variables a..h; a sits in the top word so the packed form matches {H0..H7}.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam work_t IV_STATE = '{IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// rtl/sha256_compress_if.sv - control, schedule-word and digest bundle of the compressor
interface sha256_compress_if;

    logic         C_start;
    logic         first_block;
    logic         W_valid;
    logic [31:0]  W_data;
    logic         busy;
    logic         digest_valid;
    logic [255:0] digest;

    modport master (
        output C_start, first_block, W_valid, W_data,
        input  busy, digest_valid, digest
    );

    modport slave (
        input  C_start, first_block, W_valid, W_data,
        output busy, digest_valid, digest
    );

endinterface

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       cur,
    input  logic [31:0] k,
    input  logic [31:0] w,
    output work_t       nxt
);

    logic [31:0] t1;
    logic [31:0] t2;

    assign t1 = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    assign t2 = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);

    // Shift the working variables down one slot, injecting the new a and e.
    always_comb begin
        nxt   = cur;
        nxt.h = cur.g;
        nxt.g = cur.f;
        nxt.f = cur.e;
        nxt.e = cur.d + t1;
        nxt.d = cur.c;
        nxt.c = cur.b;
        nxt.b = cur.a;
        nxt.a = t1 + t2;
    end

endmodule

// File: rtl/sha256_compress.sv
// rtl/sha256_compress.sv - 64-round SHA-256 block compressor with chaining state
module sha256_compress
    import sha256_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic             clk,
    input  logic             reset,
    sha256_compress_if.slave bus
);

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    state_t state;
    state_t state_nxt;

    work_t  work;
    work_t  work_nxt;
    work_t  h_reg;
    work_t  h_sum;

    logic [5:0]   round_cnt;
    logic [255:0] digest_reg;
    logic         busy_c;
    logic         digest_valid_c;
    logic         last_round;

    assign last_round = (round_cnt == LAST_ROUND);

    sha256_round u_round (
        .cur (work),
        .k   (K[round_cnt]),
        .w   (bus.W_data),
        .nxt (work_nxt)
    );

    // Feed-forward: each chaining word plus its working variable, mod 2^32.
    always_comb begin
        h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum[i*WORD_W +: WORD_W] = h_reg[i*WORD_W +: WORD_W] + work[i*WORD_W +: WORD_W];
        end
    end

    // State register; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; busy drops in DONE while digest_valid pulses.
    always_comb begin
        state_nxt      = state;
        busy_c         = 1'b0;
        digest_valid_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.C_start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy_c    = 1'b1;
                state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                busy_c = 1'b1;
                if (bus.W_valid && last_round) begin
                    state_nxt = ST_FINAL;
                end
            end
            ST_FINAL: begin
                busy_c    = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                digest_valid_c = 1'b1;
                state_nxt      = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: IV load, working-variable init, stall-aware rounds, feed-forward into H and digest.
    always_ff @(posedge clk) begin
        if (!reset) begin
            work       <= '0;
            h_reg      <= IV_STATE;
            digest_reg <= '0;
            round_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.C_start && bus.first_block) begin
                        h_reg <= IV_STATE;
                    end
                end
                ST_LOAD: begin
                    work      <= h_reg;
                    round_cnt <= '0;
                end
                ST_ROUND: begin
                    if (bus.W_valid) begin
                        work      <= work_nxt;
                        round_cnt <= round_cnt + 6'd1;
                    end
                end
                ST_FINAL: begin
                    h_reg      <= h_sum;
                    digest_reg <= h_sum;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy         = busy_c;
    assign bus.digest_valid = digest_valid_c;
    assign bus.digest       = digest_reg;

endmodule

// File: tb/tb_sha256_compress.sv
// tb/tb_sha256_compress.sv - scoreboard bench for the SHA-256 compressor
module tb_sha256_compress;

    typedef logic [31:0] words_t [64];

    typedef struct {
        logic [255:0] dig;
        bit           exact;
        int           cyc;
    } sb_t;

    localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    sb_t  exp_q[$];

    words_t w_abc;
    words_t w_empty;
    words_t w_two1;
    words_t w_two2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha256_compress_if bus ();

    sha256_compress #(.WORD_W(32), .ROUNDS(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic words_t expand(input words_t m);
        words_t w;
        logic [31:0] s0;
        logic [31:0] s1;
        w = m;
        for (int t = 16; t < 64; t++) begin
            s0   = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every digest_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && bus.digest_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_digest_valid: got digest %h at cycle %0d, required no pulse", bus.digest, cyc);
            end else begin
                sb_t e;
                e = exp_q.pop_front();
                if (e.exact) begin
                    check("digest", bus.digest, e.dig);
                end else begin
                    n_checks++;
                    if (bus.digest === e.dig) begin
                        n_fail++;
                        $display("FAIL intermediate_digest: got %h, required anything but the final digest", bus.digest);
                    end
                end
                check("latency", 256'(cyc), 256'(e.cyc));
            end
        end
    end

    // One block: start, optional stall burst before word stall_at, optional C_start pulse at word pulse_at.
    task automatic run_block(input words_t w, input logic first, input bit exact, input logic [255:0] dig,
                             input int stall_at, input int stall_len, input int pulse_at);
        int  n0;
        int  busy_bad;
        sb_t e;
        busy_bad = 0;
        @(posedge clk); #1;
        bus.C_start     = 1'b1;
        bus.first_block = first;
        @(posedge clk); #1;
        n0              = cyc;
        bus.C_start     = 1'b0;
        bus.first_block = 1'b0;
        e.dig   = dig;
        e.exact = exact;
        e.cyc   = n0 + 66 + stall_len;
        exp_q.push_back(e);
        if (bus.busy !== 1'b1) busy_bad++;
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus.W_valid = 1'b0;
                    bus.W_data  = 32'hdeadbeef;
                    if (bus.busy !== 1'b1) busy_bad++;
                    @(posedge clk); #1;
                end
            end
            bus.C_start     = (i == pulse_at);
            bus.first_block = (i == pulse_at);
            bus.W_valid     = 1'b1;
            bus.W_data      = w[i];
            if (bus.busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
        end
        bus.W_valid     = 1'b0;
        bus.C_start     = 1'b0;
        bus.first_block = 1'b0;
        check("busy_held", 256'(busy_bad), 256'(0));
        for (int j = 0; j < 12 && exp_q.size() != 0; j++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL digest_timeout: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        words_t m;
        bus.C_start     = 1'b0;
        bus.first_block = 1'b0;
        bus.W_valid     = 1'b0;
        bus.W_data      = '0;

        m = '{default: 32'h0};
        m[0] = 32'h61626380; m[15] = 32'h00000018;
        w_abc = expand(m);

        m = '{default: 32'h0};
        m[0] = 32'h80000000;
        w_empty = expand(m);

        m = '{default: 32'h0};
        m[0]  = 32'h61626364; m[1]  = 32'h62636465; m[2]  = 32'h63646566; m[3]  = 32'h64656667;
        m[4]  = 32'h65666768; m[5]  = 32'h66676869; m[6]  = 32'h6768696a; m[7]  = 32'h68696a6b;
        m[8]  = 32'h696a6b6c; m[9]  = 32'h6a6b6c6d; m[10] = 32'h6b6c6d6e; m[11] = 32'h6c6d6e6f;
        m[12] = 32'h6d6e6f70; m[13] = 32'h6e6f7071; m[14] = 32'h80000000; m[15] = 32'h00000000;
        w_two1 = expand(m);

        m = '{default: 32'h0};
        m[15] = 32'h000001c0;
        w_two2 = expand(m);

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check("reset_busy", 256'(bus.busy), 256'(0));
        check("reset_digest_valid", 256'(bus.digest_valid), 256'(0));
        check("reset_digest", bus.digest, 256'h0);

        run_block(w_abc, 1'b1, 1'b1, ABC_DIG, -1, 0, -1);
        run_block(w_empty, 1'b1, 1'b1, EMPTY_DIG, -1, 0, -1);
        run_block(w_two1, 1'b1, 1'b0, TWO_DIG, -1, 0, -1);
        run_block(w_two2, 1'b0, 1'b1, TWO_DIG, -1, 0, 20);

        for (int r = 0; r < 20; r++) begin
            run_block(w_abc, 1'b1, 1'b1, ABC_DIG, int'($urandom_range(0, 63)), int'($urandom_range(1, 5)), -1);
        end

        @(posedge clk); #1;
        bus.C_start     = 1'b1;
        bus.first_block = 1'b1;
        @(posedge clk); #1;
        bus.C_start     = 1'b0;
        bus.first_block = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 30; i++) begin
            bus.W_valid = 1'b1;
            bus.W_data  = w_abc[i];
            @(posedge clk); #1;
        end
        bus.W_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("abort_busy", 256'(bus.busy), 256'(0));
        check("abort_digest", bus.digest, 256'h0);
        check("abort_digest_valid", 256'(bus.digest_valid), 256'(0));
        repeat (80) @(posedge clk);
        #1;

        run_block(w_abc, 1'b0, 1'b1, ABC_DIG, -1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
